// File: rtl/ps2_command_tx.sv
// ps2_command_tx
// Host-to-device PS/2 transmitter. Takes command bytes over a valid/ready
// interface, performs the PS/2 request-to-send sequence, shifts the byte,
// odd parity and stop bit out on device-generated clock falling edges,
// samples the device acknowledge bit and returns one ack/error result per
// command over a second valid/ready interface.
//
// Ports:
//   clk                 system clock
//   reset               synchronous, active-high reset
//   command_ready       block can accept a command byte (combinational)
//   command_valid       command byte offered
//   command_byte        byte to transmit
//   command_ack_ready   consumer takes the ack result
//   command_ack_valid   ack result pending
//   command_ack_error   qualifies ack: 1 = NACK or timeout
//   ps2_clk_in          raw PS/2 clock pad level (asynchronous)
//   ps2_data_in         raw PS/2 data pad level (asynchronous)
//   ps2_clk_drive_low   1 = pull PS/2 clock low, 0 = release
//   ps2_data_drive_low  1 = pull PS/2 data low, 0 = release
//   busy                transmit in progress
//
// Build option:
//   PS2_TX_FILTER_EN    when defined, the synced PS/2 clock passes through a
//                       FILTER_CYCLES-sample stability filter before edge
//                       detection.

module ps2_command_tx #(
   parameter int unsigned INHIBIT_CYCLES = 2700,
   parameter int unsigned TIMEOUT_CYCLES = 405000,
   parameter int unsigned FILTER_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       reset,
   output logic       command_ready,
   input  logic       command_valid,
   input  logic [7:0] command_byte,
   input  logic       command_ack_ready,
   output logic       command_ack_valid,
   output logic       command_ack_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low,
   output logic       busy
);

   localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
   localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRequest,
      StShift,
      StAckSample,
      StWaitIdle,
      StResult
   } state_e;

   state_e          r_state;
   logic [7:0]      r_byte;
   logic            r_parity;
   logic [InhW-1:0] r_inh_cnt;
   logic [ToW-1:0]  r_to_cnt;
   logic [3:0]      r_bit_cnt;
   logic            r_nack;
   logic            r_clk_low;
   logic            r_data_low;
   logic            r_busy;
   logic            r_ack_valid;
   logic            r_ack_error;

   logic            r_clk_meta;
   logic            r_clk_sync;
   logic            r_data_meta;
   logic            r_data_sync;
   logic            r_clk_prev;

   logic            w_clk_level;
   logic            w_clk_fall;
   logic            w_accept;
   logic            w_active;
   logic            w_timeout;

   // Two-flop synchronisers; idle bus level is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
      end else begin
         r_clk_meta  <= ps2_clk_in;
         r_clk_sync  <= r_clk_meta;
         r_data_meta <= ps2_data_in;
         r_data_sync <= r_data_meta;
      end
   end

`ifdef PS2_TX_FILTER_EN
   localparam int unsigned FiltW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_CYCLES - 1);

   logic [FiltW-1:0] r_filt_cnt;
   logic             r_clk_filt;

   // The filtered level flips only after FILTER_CYCLES consecutive samples
   // that disagree with it; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_filt_cnt <= '0;
         r_clk_filt <= 1'b1;
      end else if (r_clk_sync == r_clk_filt) begin
         r_filt_cnt <= '0;
      end else if (r_filt_cnt == FiltLast) begin
         r_filt_cnt <= '0;
         r_clk_filt <= r_clk_sync;
      end else begin
         r_filt_cnt <= r_filt_cnt + 1'b1;
      end
   end

   assign w_clk_level = r_clk_filt;
`else
   logic w_unused_filter;
   assign w_unused_filter = ^FILTER_CYCLES;
   assign w_clk_level     = r_clk_sync;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_prev <= w_clk_level;
      end
   end

   assign w_clk_fall = r_clk_prev & ~w_clk_level;

   assign command_ready = ~reset & (r_state == StIdle) & ~r_ack_valid;
   assign w_accept      = command_valid & command_ready;

   // States covered by the line-idle timeout.
   assign w_active  = (r_state == StRequest) || (r_state == StShift) ||
                      (r_state == StAckSample) || (r_state == StWaitIdle);
   assign w_timeout = (r_to_cnt == ToLast);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_byte      <= '0;
         r_parity    <= 1'b0;
         r_inh_cnt   <= '0;
         r_to_cnt    <= '0;
         r_bit_cnt   <= '0;
         r_nack      <= 1'b0;
         r_clk_low   <= 1'b0;
         r_data_low  <= 1'b0;
         r_busy      <= 1'b0;
         r_ack_valid <= 1'b0;
         r_ack_error <= 1'b0;
      end else if (w_active && w_timeout) begin
         // Abandon the transfer: release both lines and report an error.
         r_clk_low   <= 1'b0;
         r_data_low  <= 1'b0;
         r_ack_valid <= 1'b1;
         r_ack_error <= 1'b1;
         r_state     <= StResult;
      end else begin
         // Never wraps: the counter is abandoned once it reaches ToLast.
         if (w_active) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_byte    <= command_byte;
                  r_parity  <= ~^command_byte;
                  r_inh_cnt <= '0;
                  r_clk_low <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= StInhibit;
               end
            end
            StInhibit: begin
               if (r_inh_cnt == InhLast) begin
                  r_data_low <= 1'b1;
                  r_to_cnt   <= '0;
                  r_state    <= StRequest;
               end else begin
                  r_inh_cnt <= r_inh_cnt + 1'b1;
               end
            end
            StRequest: begin
               r_clk_low <= 1'b0;
               if (w_clk_fall) begin
                  r_data_low <= ~r_byte[0];
                  r_bit_cnt  <= 4'd1;
                  r_state    <= StShift;
               end
            end
            StShift: begin
               if (w_clk_fall) begin
                  if (r_bit_cnt < 4'd8) begin
                     r_data_low <= ~r_byte[r_bit_cnt[2:0]];
                  end else if (r_bit_cnt == 4'd8) begin
                     r_data_low <= ~r_parity;
                  end else begin
                     // Stop bit: release data so the device can drive ack.
                     r_data_low <= 1'b0;
                     r_state    <= StAckSample;
                  end
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            StAckSample: begin
               if (w_clk_fall) begin
                  r_nack  <= r_data_sync;
                  r_state <= StWaitIdle;
               end
            end
            StWaitIdle: begin
               if (r_clk_sync && r_data_sync) begin
                  r_ack_valid <= 1'b1;
                  r_ack_error <= r_nack;
                  r_state     <= StResult;
               end
            end
            StResult: begin
               if (command_ack_ready) begin
                  r_ack_valid <= 1'b0;
                  r_ack_error <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign ps2_clk_drive_low  = r_clk_low;
   assign ps2_data_drive_low = r_data_low;
   assign busy               = r_busy;
   assign command_ack_valid  = r_ack_valid;
   assign command_ack_error  = r_ack_error;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Testbench for ps2_command_tx. A behavioural PS/2 device drives the
// open-drain lines (wired-AND with the DUT pull-downs), captures the frame
// the host shifts out and returns ACK or NACK. Expected results are queued
// when a command is sent and popped when the DUT posts its ack result.

module tb_ps2_command_tx;

   localparam int unsigned Inhibit = 2700;
   localparam int unsigned Timeout = 6000;
   localparam int          Half    = 40;

   typedef struct {
      logic [7:0] b;
      logic       err;
      logic       has_frame;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       command_ready;
   logic       command_valid;
   logic [7:0] command_byte;
   logic       command_ack_ready;
   logic       command_ack_valid;
   logic       command_ack_error;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_drive_low;
   logic       ps2_data_drive_low;
   logic       busy;

   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;

   int         total = 0;
   int         bad   = 0;
   exp_t       sb[$];

   assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
   assign ps2_data_in = dev_data & ~ps2_data_drive_low;

   always #5 clk = ~clk;

   ps2_command_tx #(
      .INHIBIT_CYCLES(Inhibit),
      .TIMEOUT_CYCLES(Timeout),
      .FILTER_CYCLES (8)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .command_ready     (command_ready),
      .command_valid     (command_valid),
      .command_byte      (command_byte),
      .command_ack_ready (command_ack_ready),
      .command_ack_valid (command_ack_valid),
      .command_ack_error (command_ack_error),
      .ps2_clk_in        (ps2_clk_in),
      .ps2_data_in       (ps2_data_in),
      .ps2_clk_drive_low (ps2_clk_drive_low),
      .ps2_data_drive_low(ps2_data_drive_low),
      .busy              (busy)
   );

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      command_byte  = b;
      command_valid = 1'b1;
      while (!command_ready && n < 100) begin
         tick();
         n++;
      end
      check("accept_ready", command_ready, 1'b1);
      tick();
      command_valid = 1'b0;
   endtask

   // Device side of one host-to-device frame. Returns early (clock left low)
   // right after falling edge number abort_after, if that is 1..11.
   task automatic device(input logic ack_bit, input int abort_after, output logic [9:0] frame);
      int n = 0;
      frame = '0;
      while (!(!ps2_clk_drive_low && ps2_data_drive_low) && n < 4000) begin
         tick();
         n++;
      end
      check("request_seen", (n < 4000), 1'b1);
      if (n >= 4000) return;
      check("start_bit", ps2_data_in, 1'b0);
      repeat (Half) tick();
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) dev_data = ack_bit;
         repeat (Half) tick();
         dev_clk = 1'b0;
         if (k == abort_after) return;
         repeat (Half) tick();
         if (k <= 10) frame[k-1] = ps2_data_in;
         dev_clk = 1'b1;
      end
      repeat (Half) tick();
      dev_data = 1'b1;
   endtask

   task automatic wait_ack(input int bound, output int n);
      n = 0;
      while (!command_ack_valid && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic collect(input string tag, input logic [9:0] frame);
      exp_t e;
      int   n;
      wait_ack(400, n);
      check({tag, "_ack_valid"}, command_ack_valid, 1'b1);
      check({tag, "_sb_pending"}, (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_error"}, command_ack_error, e.err);
         if (e.has_frame) begin
            check({tag, "_frame"}, frame, {1'b1, ~^e.b, e.b});
         end
      end
   endtask

   task automatic take_ack(input string tag);
      command_ack_ready = 1'b1;
      tick();
      command_ack_ready = 1'b0;
      check({tag, "_ack_cleared"}, command_ack_valid, 1'b0);
      check({tag, "_ready_after"}, command_ready, 1'b1);
      check({tag, "_busy_after"}, busy, 1'b0);
   endtask

   initial begin
      logic [9:0] frame;
      int         n;
      int         viol;

      reset             = 1'b1;
      command_valid     = 1'b0;
      command_byte      = '0;
      command_ack_ready = 1'b0;
      repeat (3) tick();
      check("rst_ready", command_ready, 1'b0);
      check("rst_ack_valid", command_ack_valid, 1'b0);
      check("rst_ack_error", command_ack_error, 1'b0);
      check("rst_drive", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      tick();
      check("idle_ready", command_ready, 1'b1);

      // Ack-ready with no result pending changes nothing.
      command_ack_ready = 1'b1;
      tick();
      command_ack_ready = 1'b0;
      check("stray_ack_ready", {command_ready, command_ack_valid, busy}, 3'b100);

      // 0xED with ACK.
      sb.push_back('{b: 8'hED, err: 1'b0, has_frame: 1'b1});
      send(8'hED);
      check("ed_busy", busy, 1'b1);
      check("ed_ready_low", command_ready, 1'b0);
      device(1'b0, 0, frame);
      collect("ed", frame);
      take_ack("ed");

      // 0x02 with ACK, inhibit length measured.
      sb.push_back('{b: 8'h02, err: 1'b0, has_frame: 1'b1});
      send(8'h02);
      n = 0;
      while (ps2_clk_drive_low && !ps2_data_drive_low && n < 5000) begin
         n++;
         tick();
      end
      check("inhibit_cycles", n, Inhibit);
      device(1'b0, 0, frame);
      collect("x02", frame);
      take_ack("x02");

      // 0x07 with NACK.
      sb.push_back('{b: 8'h07, err: 1'b1, has_frame: 1'b1});
      send(8'h07);
      device(1'b1, 0, frame);
      collect("nack", frame);
      check("nack_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
      take_ack("nack");

      // 0xED with no device clock: timeout.
      sb.push_back('{b: 8'hED, err: 1'b1, has_frame: 1'b0});
      send(8'hED);
      n = 0;
      while (!ps2_data_drive_low && n < 3000) begin
         tick();
         n++;
      end
      check("to_request", ps2_data_drive_low, 1'b1);
      wait_ack(Timeout + 100, n);
      check("to_latency", (n >= Timeout - 2) && (n <= Timeout + 2), 1'b1);
      collect("to", frame);
      check("to_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
      check("to_busy", busy, 1'b1);

      // Backpressure: result held for 1000 cycles.
      viol = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (command_ack_valid !== 1'b1 || command_ack_error !== 1'b1 ||
             command_ready !== 1'b0 || busy !== 1'b1) viol++;
      end
      check("hold_stable_violations", viol, 0);
      take_ack("to");

      // Reset after the 5th falling edge: no result, lines released.
      send(8'hA5);
      device(1'b0, 5, frame);
      repeat (10) tick();
      check("mid_busy", busy, 1'b1);
      reset = 1'b1;
      tick();
      check("mid_rst_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
      check("mid_rst_ack", command_ack_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      reset    = 1'b0;
      viol     = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (command_ack_valid !== 1'b0) viol++;
      end
      check("mid_no_ack", viol, 0);
      check("mid_ready", command_ready, 1'b1);

      // 0xF4 after the aborted transfer.
      sb.push_back('{b: 8'hF4, err: 1'b0, has_frame: 1'b1});
      send(8'hF4);
      device(1'b0, 0, frame);
      collect("f4", frame);
      take_ack("f4");

      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
